// File: rtl/program_loader_if.sv
`default_nettype none
// ============================================================================
//  Module      : program_loader_if
//  Description : Bundles the signals between the host-side byte link, the
//                program loader and the instruction-memory write port.
//
//                Signals:
//                  start       host -> loader   1-cycle pulse that arms a load
//                  in_valid    host -> loader   byte on in_data is valid
//                  in_data     host -> loader   stream byte
//                  in_ready    loader -> host   loader takes a byte this cycle
//                  instr_we    loader -> imem   instruction_Write_en
//                  instr_addr  loader -> imem   Write_address (word index)
//                  instr_data  loader -> imem   Write_instruction
//                  cpu_reset   loader -> cpu    processor held in reset
//                  done        loader -> host   load complete
//                  error       loader -> host   load rejected or timed out
//
//                Modports:
//                  master  host / system side
//                  slave   the loader itself
//  Revision    : 1.0  initial release
// ============================================================================
interface program_loader_if;
    logic        start;
    logic        in_valid;
    logic [7:0]  in_data;
    logic        in_ready;
    logic        instr_we;
    logic [31:0] instr_addr;
    logic [31:0] instr_data;
    logic        cpu_reset;
    logic        done;
    logic        error;

    modport master (
        output start, in_valid, in_data,
        input  in_ready, instr_we, instr_addr, instr_data, cpu_reset, done, error
    );

    modport slave (
        input  start, in_valid, in_data,
        output in_ready, instr_we, instr_addr, instr_data, cpu_reset, done, error
    );
endinterface
`default_nettype wire

// File: rtl/program_loader.sv
`default_nettype none
// ============================================================================
//  Module      : program_loader
//  Description : Writer side of the instruction-memory load port. Receives a
//                byte stream (LEN_HI, LEN_LO, then 4*N bytes, MSB first per
//                word), assembles big-endian 32-bit words and writes them to
//                consecutive word addresses from 0. The processor is held in
//                reset until the complete image has been written.
//
//  Ports       : clk    clock, rising edge
//                reset  asynchronous, active-high
//                bus    program_loader_if.slave (byte stream in, memory
//                       write port, cpu_reset / done / error status out)
//
//  Parameters  : MEM_WORDS       instruction memory depth in words; a larger
//                                length field is rejected
//                TIMEOUT_CYCLES  max idle cycles between accepted bytes once
//                                a load has started
//  Revision    : 1.0  initial release
// ============================================================================
module program_loader #(
    parameter int MEM_WORDS      = 200,
    parameter int TIMEOUT_CYCLES = 1000
) (
    input  wire logic       clk,
    input  wire logic       reset,
    program_loader_if.slave bus
);

    // The idle counter only ever needs to reach TIMEOUT_CYCLES-1: that is the
    // value at which the next idle cycle raises the timeout.
    localparam int              IDLE_W    = (TIMEOUT_CYCLES > 1) ? $clog2(TIMEOUT_CYCLES) : 1;
    localparam logic [IDLE_W-1:0] IDLE_LAST = IDLE_W'(TIMEOUT_CYCLES - 1);
    localparam logic [15:0]     MAX_WORDS = 16'(MEM_WORDS);

    typedef enum logic [2:0] {
        S_IDLE   = 3'd0,
        S_LEN_HI = 3'd1,
        S_LEN_LO = 3'd2,
        S_DATA   = 3'd3,
        S_WRITE  = 3'd4,
        S_DONE   = 3'd5,
        S_ERROR  = 3'd6
    } state_t;

    state_t              state;
    state_t              state_next;

    logic [7:0]          len_hi;
    logic [15:0]         word_count;
    logic [15:0]         word_idx;
    logic [1:0]          byte_cnt;
    logic [23:0]         shift;
    logic [IDLE_W-1:0]   idle_cnt;
    logic [31:0]         addr_q;
    logic [31:0]         data_q;

    logic                ready;
    logic                accept;
    logic                timeout_hit;
    logic [15:0]         len_full;

    assign ready       = (state == S_LEN_HI) || (state == S_LEN_LO) || (state == S_DATA);
    assign accept      = bus.in_valid & ready;
    assign len_full    = {len_hi, bus.in_data};
    // Only meaningful in a cycle where no byte is accepted.
    assign timeout_hit = (idle_cnt == IDLE_LAST);

    // ------------------------------------------------------------------
    // State register
    // ------------------------------------------------------------------
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state <= S_IDLE;
        end else begin
            state <= state_next;
        end
    end

    // ------------------------------------------------------------------
    // Next-state logic
    // ------------------------------------------------------------------
    always_comb begin
        state_next = state;
        case (state)
            S_IDLE, S_DONE, S_ERROR: begin
                if (bus.start) begin
                    state_next = S_LEN_HI;
                end
            end
            S_LEN_HI: begin
                // No byte of this load has been taken yet, so no timeout here.
                if (accept) begin
                    state_next = S_LEN_LO;
                end
            end
            S_LEN_LO: begin
                if (accept) begin
                    if (len_full == 16'd0) begin
                        state_next = S_DONE;
                    end else if (len_full > MAX_WORDS) begin
                        state_next = S_ERROR;
                    end else begin
                        state_next = S_DATA;
                    end
                end else if (timeout_hit) begin
                    state_next = S_ERROR;
                end
            end
            S_DATA: begin
                if (accept) begin
                    if (byte_cnt == 2'd3) begin
                        state_next = S_WRITE;
                    end
                end else if (timeout_hit) begin
                    state_next = S_ERROR;
                end
            end
            S_WRITE: begin
                if (word_idx == (word_count - 16'd1)) begin
                    state_next = S_DONE;
                end else begin
                    state_next = S_DATA;
                end
            end
            default: begin
                state_next = S_IDLE;
            end
        endcase
    end

    // ------------------------------------------------------------------
    // Datapath: length, word assembly, write port registers, idle counter
    // ------------------------------------------------------------------
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            len_hi     <= 8'd0;
            word_count <= 16'd0;
            word_idx   <= 16'd0;
            byte_cnt   <= 2'd0;
            shift      <= 24'd0;
            idle_cnt   <= '0;
            addr_q     <= 32'd0;
            data_q     <= 32'd0;
        end else begin
            if ((state == S_LEN_HI) && accept) begin
                len_hi <= bus.in_data;
            end

            if ((state == S_LEN_LO) && accept) begin
                word_count <= len_full;
                word_idx   <= 16'd0;
                byte_cnt   <= 2'd0;
            end

            if ((state == S_DATA) && accept) begin
                shift    <= {shift[15:0], bus.in_data};
                byte_cnt <= byte_cnt + 2'd1;
                // Capture the write port contents on the 4th byte so they are
                // stable for the whole WRITE cycle.
                if (byte_cnt == 2'd3) begin
                    data_q <= {shift, bus.in_data};
                    addr_q <= {16'd0, word_idx};
                end
            end

            if (state == S_WRITE) begin
                word_idx <= word_idx + 16'd1;
                byte_cnt <= 2'd0;
            end

            // Idle counter: cleared by any accepted byte and when a new load
            // is armed; counts only while waiting for length or data bytes.
            if (accept || ((state_next == S_LEN_HI) && (state != S_LEN_HI))) begin
                idle_cnt <= '0;
            end else if ((state == S_LEN_LO) || (state == S_DATA)) begin
                idle_cnt <= idle_cnt + IDLE_W'(1);
            end
        end
    end

    // ------------------------------------------------------------------
    // Outputs (all derived from registers)
    // ------------------------------------------------------------------
    assign bus.in_ready   = ready;
    assign bus.instr_we   = (state == S_WRITE);
    assign bus.instr_addr = addr_q;
    assign bus.instr_data = data_q;
    assign bus.cpu_reset  = (state != S_DONE);
    assign bus.done       = (state == S_DONE);
    assign bus.error      = (state == S_ERROR);

endmodule
`default_nettype wire
